// File: rtl/dkong_debug_ctrl.sv
// rtl/dkong_debug_ctrl.sv - run-control and banked snapshot sequencer for the dkong_system debug port
module dkong_debug_ctrl #(
  parameter bit HALT_ON_RESET = 1'b1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        masterclk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        brk_ena,
  input  logic [15:0] brk_addr,
  input  logic [7:0]  dbg_ahi,
  input  logic [7:0]  dbg_alo,
  input  logic [7:0]  dbg_dmaster,
  input  logic [7:0]  dbg_dslave,
  input  logic [7:0]  dbg_cpu_sig,
  input  logic [7:0]  dbg_enables,
  output logic        debug_wait,
  output logic [1:0]  debug_banksel,
  output logic        snap_valid,
  input  logic        snap_ready,
  output logic [1:0]  snap_bank,
  output logic [47:0] snap_data,
  output logic        halted,
  output logic        brk_hit
);

  typedef enum logic [2:0] {
    S_RUN, S_HALT, S_STEP_A, S_STEP_B, S_SNAP_SEL, S_SNAP_CAP, S_SNAP_OUT
  } state_t;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_SNAP = 2'b11;

  localparam state_t     RESET_STATE = HALT_ON_RESET ? S_HALT : S_RUN;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  bank_q, bank_d;
  logic [3:0]  settle_q, settle_d;
  logic        m1_prev_q, m1_prev_d;
  logic        brk_pend_q, brk_pend_d;
  logic        brk_hit_q, brk_hit_d;
  logic        debug_wait_q, debug_wait_d;
  logic [1:0]  banksel_q, banksel_d;
  logic        snap_valid_q, snap_valid_d;
  logic [1:0]  snap_bank_q, snap_bank_d;
  logic [47:0] snap_data_q, snap_data_d;
  logic        cmd_ready_q, cmd_ready_d;

  logic m1, m1_rise, cmd_acc, bp_fire, in_snap;

  always_comb begin
    m1       = dbg_cpu_sig[0];
    m1_rise  = m1 & ~m1_prev_q;
    cmd_acc  = cmd_valid & cmd_ready_q;
    bp_fire  = brk_ena & m1_rise & ({dbg_ahi, dbg_alo} == brk_addr);
    in_snap  = (state_q == S_SNAP_SEL) || (state_q == S_SNAP_CAP) || (state_q == S_SNAP_OUT);

    state_d      = state_q;
    bank_d       = bank_q;
    settle_d     = settle_q;
    m1_prev_d    = m1;
    brk_pend_d   = 1'b0;
    snap_valid_d = snap_valid_q;
    snap_bank_d  = snap_bank_q;
    snap_data_d  = snap_data_q;

    case (state_q)
      S_RUN: begin
        // A breakpoint hit swallows any command accepted on the same edge.
        if (bp_fire) begin
          state_d    = S_HALT;
          brk_pend_d = 1'b1;
        end else if (cmd_acc && (cmd_op == OP_HALT || cmd_op == OP_STEP)) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (cmd_acc) begin
          case (cmd_op)
            OP_RUN:  state_d = S_RUN;
            OP_STEP: state_d = S_STEP_A;
            OP_SNAP: begin
              state_d = S_SNAP_SEL;
              bank_d  = 2'd0;
            end
            default: state_d = S_HALT;
          endcase
        end
      end
      S_STEP_A: if (!m1) state_d = S_STEP_B;
      S_STEP_B: if (m1_rise) state_d = S_HALT;
      S_SNAP_SEL: begin
        settle_d = SETTLE_LOAD;
        state_d  = S_SNAP_CAP;
      end
      S_SNAP_CAP: begin
        if (settle_q == 4'd0) begin
          snap_data_d  = {dbg_ahi, dbg_alo, dbg_dmaster, dbg_dslave, dbg_cpu_sig, dbg_enables};
          snap_bank_d  = bank_q;
          snap_valid_d = 1'b1;
          state_d      = S_SNAP_OUT;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_SNAP_OUT: begin
        if (snap_ready) begin
          snap_valid_d = 1'b0;
          if (bank_q == 2'd3) begin
            state_d = S_HALT;
          end else begin
            bank_d  = bank_q + 2'd1;
            state_d = S_SNAP_SEL;
          end
        end
      end
      default: state_d = RESET_STATE;
    endcase

    brk_hit_d    = brk_pend_q;
    debug_wait_d = !((state_q == S_RUN) || (state_q == S_STEP_A) || (state_q == S_STEP_B));
    banksel_d    = in_snap ? bank_q : 2'd0;
    cmd_ready_d  = (state_d == S_RUN) || (state_d == S_HALT);
  end

  always_ff @(posedge masterclk) begin
    if (rst) begin
      state_q      <= RESET_STATE;
      bank_q       <= 2'd0;
      settle_q     <= 4'd0;
      m1_prev_q    <= 1'b1;
      brk_pend_q   <= 1'b0;
      brk_hit_q    <= 1'b0;
      debug_wait_q <= HALT_ON_RESET;
      banksel_q    <= 2'd0;
      snap_valid_q <= 1'b0;
      snap_bank_q  <= 2'd0;
      snap_data_q  <= 48'd0;
      cmd_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      settle_q     <= settle_d;
      m1_prev_q    <= m1_prev_d;
      brk_pend_q   <= brk_pend_d;
      brk_hit_q    <= brk_hit_d;
      debug_wait_q <= debug_wait_d;
      banksel_q    <= banksel_d;
      snap_valid_q <= snap_valid_d;
      snap_bank_q  <= snap_bank_d;
      snap_data_q  <= snap_data_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign debug_wait    = debug_wait_q;
  assign halted        = debug_wait_q;
  assign debug_banksel = banksel_q;
  assign snap_valid    = snap_valid_q;
  assign snap_bank     = snap_bank_q;
  assign snap_data     = snap_data_q;
  assign brk_hit       = brk_hit_q;

endmodule

// File: tb/tb_dkong_debug_ctrl.sv
// tb/tb_dkong_debug_ctrl.sv - self-checking bench for dkong_debug_ctrl
module tb_dkong_debug_ctrl;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_SNAP = 2'b11;

  logic        masterclk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, brk_ena;
  logic [1:0]  cmd_op;
  logic [15:0] brk_addr;
  logic [7:0]  dbg_ahi, dbg_alo, dbg_dmaster, dbg_dslave, dbg_cpu_sig, dbg_enables;
  logic        debug_wait, snap_valid, snap_ready, halted, brk_hit;
  logic [1:0]  debug_banksel, snap_bank;
  logic [47:0] snap_data;

  logic        snap_mode, m1_drv;
  logic [15:0] addr_drv;
  logic [7:0]  sb;

  int checks = 0;
  int errors = 0;
  int brk_cnt = 0;
  logic [49:0] exp_q[$];

  always #5 masterclk = ~masterclk;

  // In snap mode every bus reflects the selected bank so each record is traceable.
  assign sb          = {2'b00, debug_banksel, 4'b0000};
  assign dbg_ahi     = snap_mode ? sb          : addr_drv[15:8];
  assign dbg_alo     = snap_mode ? sb + 8'd1   : addr_drv[7:0];
  assign dbg_dmaster = snap_mode ? sb + 8'd2   : 8'h00;
  assign dbg_dslave  = snap_mode ? sb + 8'd3   : 8'h00;
  assign dbg_cpu_sig = snap_mode ? sb + 8'd4   : {7'b0, m1_drv};
  assign dbg_enables = snap_mode ? sb + 8'd5   : 8'h00;

  dkong_debug_ctrl #(.HALT_ON_RESET(1'b1), .SETTLE_CYCLES(2)) dut (
    .masterclk(masterclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .brk_ena(brk_ena), .brk_addr(brk_addr),
    .dbg_ahi(dbg_ahi), .dbg_alo(dbg_alo), .dbg_dmaster(dbg_dmaster), .dbg_dslave(dbg_dslave),
    .dbg_cpu_sig(dbg_cpu_sig), .dbg_enables(dbg_enables),
    .debug_wait(debug_wait), .debug_banksel(debug_banksel), .snap_valid(snap_valid),
    .snap_ready(snap_ready), .snap_bank(snap_bank), .snap_data(snap_data),
    .halted(halted), .brk_hit(brk_hit)
  );

  function automatic logic [49:0] exp_rec(input logic [1:0] b);
    logic [7:0] base;
    base = {2'b00, b, 4'b0000};
    return {b, base, base + 8'd1, base + 8'd2, base + 8'd3, base + 8'd4, base + 8'd5};
  endfunction

  task automatic step();
    @(posedge masterclk);
    #1;
    if (brk_hit) brk_cnt++;
  endtask

  task automatic push_all();
    exp_q.delete();
    for (int b = 0; b < 4; b++) exp_q.push_back(exp_rec(2'(b)));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (debug_wait !== 1'b1) begin errors++; $display("FAIL reset_wait got %b want 1", debug_wait); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted got %b want 1", halted); end
    checks++; if (debug_banksel !== 2'd0) begin errors++; $display("FAIL reset_banksel got %0d want 0", debug_banksel); end
    checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL reset_snap_valid got %b want 0", snap_valid); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (brk_hit !== 1'b0) begin errors++; $display("FAIL reset_brk_hit got %b want 0", brk_hit); end
    cmd_valid = 1'b1; cmd_op = OP_RUN;
    step();
    cmd_valid = 1'b0;
    checks++; if (debug_wait !== 1'b1) begin errors++; $display("FAIL run_wait_lag got %b want 1", debug_wait); end
    step();
    checks++; if (debug_wait !== 1'b0) begin errors++; $display("FAIL run_wait got %b want 0", debug_wait); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL run_halted got %b want 0", halted); end
  endtask

  task automatic test_breakpoint();
    logic [15:0] miss[2];
    miss[0] = 16'h00FE; miss[1] = 16'h00FF;
    brk_ena = 1'b1; brk_addr = 16'h0100; brk_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      addr_drv = miss[i]; m1_drv = 1'b1;
      step();
      m1_drv = 1'b0;
      step();
      checks++; if (debug_wait !== 1'b0) begin errors++; $display("FAIL bp_miss_wait addr %h got %b want 0", miss[i], debug_wait); end
    end
    addr_drv = 16'h0100; m1_drv = 1'b1; cmd_valid = 1'b1; cmd_op = OP_RUN;
    step();
    cmd_valid = 1'b0;
    checks++; if (brk_hit !== 1'b0) begin errors++; $display("FAIL bp_hit_early got %b want 0", brk_hit); end
    checks++; if (debug_wait !== 1'b0) begin errors++; $display("FAIL bp_wait_early got %b want 0", debug_wait); end
    step();
    checks++; if (brk_hit !== 1'b1) begin errors++; $display("FAIL bp_hit got %b want 1", brk_hit); end
    checks++; if (debug_wait !== 1'b1) begin errors++; $display("FAIL bp_wait got %b want 1", debug_wait); end
    step();
    checks++; if (brk_hit !== 1'b0) begin errors++; $display("FAIL bp_hit_pulse got %b want 0", brk_hit); end
    checks++; if (debug_wait !== 1'b1) begin errors++; $display("FAIL bp_wait_hold got %b want 1", debug_wait); end
    checks++; if (brk_cnt !== 1) begin errors++; $display("FAIL bp_count got %0d want 1", brk_cnt); end
  endtask

  task automatic test_step();
    brk_addr = 16'h0201; addr_drv = 16'h0200; m1_drv = 1'b1;
    step();
    cmd_valid = 1'b1; cmd_op = OP_STEP;
    step();
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL step_cmd_ready got %b want 0", cmd_ready); end
    checks++; if (debug_wait !== 1'b1) begin errors++; $display("FAIL step_wait_lag got %b want 1", debug_wait); end
    step();
    checks++; if (debug_wait !== 1'b0) begin errors++; $display("FAIL step_release got %b want 0", debug_wait); end
    step();
    m1_drv = 1'b0;
    step();
    step();
    addr_drv = 16'h0201; m1_drv = 1'b1;
    step();
    checks++; if (debug_wait !== 1'b0) begin errors++; $display("FAIL step_wait_lag2 got %b want 0", debug_wait); end
    step();
    checks++; if (debug_wait !== 1'b1) begin errors++; $display("FAIL step_rehalt got %b want 1", debug_wait); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL step_halt_ready got %b want 1", cmd_ready); end
    checks++; if (brk_cnt !== 1) begin errors++; $display("FAIL step_no_brk got %0d want 1", brk_cnt); end
  endtask

  task automatic test_snapshot();
    logic [49:0] e;
    int nvalid;
    snap_mode = 1'b1; snap_ready = 1'b1; nvalid = 0;
    push_all();
    cmd_valid = 1'b1; cmd_op = OP_SNAP;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      checks++; if (debug_wait !== 1'b1) begin errors++; $display("FAIL snap_wait k=%0d got %b want 1", k, debug_wait); end
      if (k == 1) begin
        checks++; if (debug_banksel !== 2'd0) begin errors++; $display("FAIL snap_first_sel got %0d want 0", debug_banksel); end
      end
      if (k == 3) begin
        checks++; if (snap_valid !== 1'b1) begin errors++; $display("FAIL snap_first_valid got %b want 1", snap_valid); end
      end
      if (snap_valid) begin
        nvalid++;
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL snap_extra bank %0d got record want none", snap_bank);
        end else begin
          e = exp_q.pop_front();
          checks++; if (snap_bank !== e[49:48]) begin errors++; $display("FAIL snap_bank got %0d want %0d", snap_bank, e[49:48]); end
          checks++; if (snap_data !== e[47:0]) begin errors++; $display("FAIL snap_data got %h want %h", snap_data, e[47:0]); end
          checks++; if (debug_banksel !== e[49:48]) begin errors++; $display("FAIL snap_sel got %0d want %0d", debug_banksel, e[49:48]); end
        end
      end
      if (k == 16) begin
        checks++; if (snap_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL snap_end valid %b left %0d want 0 0", snap_valid, exp_q.size()); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL snap_end_ready got %b want 1", cmd_ready); end
      end
      if (k == 17) begin
        checks++; if (debug_banksel !== 2'd0) begin errors++; $display("FAIL snap_end_sel got %0d want 0", debug_banksel); end
      end
    end
    checks++; if (nvalid != 4) begin errors++; $display("FAIL snap_valid_cycles got %0d want 4", nvalid); end
  endtask

  task automatic test_backpressure();
    logic [49:0] e;
    logic [47:0] hold_data;
    int held;
    held = 0; hold_data = '0; snap_ready = 1'b1;
    push_all();
    cmd_valid = 1'b1; cmd_op = OP_SNAP;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 80 && exp_q.size() != 0; k++) begin
      step();
      if (snap_valid && snap_bank == 2'd1 && held < 10) begin
        if (held == 0) begin
          hold_data = snap_data;
        end else begin
          checks++; if (snap_data !== hold_data) begin errors++; $display("FAIL bp_stable got %h want %h", snap_data, hold_data); end
          checks++; if (debug_banksel !== 2'd1) begin errors++; $display("FAIL bp_sel got %0d want 1", debug_banksel); end
          checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready got %b want 0", cmd_ready); end
          checks++; if (debug_wait !== 1'b1) begin errors++; $display("FAIL bp_wait got %b want 1", debug_wait); end
        end
        snap_ready = 1'b0; cmd_valid = 1'b1; cmd_op = OP_RUN;
        held++;
      end else if (snap_valid) begin
        e = exp_q.pop_front();
        checks++; if (snap_bank !== e[49:48]) begin errors++; $display("FAIL bp_bank got %0d want %0d", snap_bank, e[49:48]); end
        checks++; if (snap_data !== e[47:0]) begin errors++; $display("FAIL bp_data got %h want %h", snap_data, e[47:0]); end
        snap_ready = 1'b1; cmd_valid = 1'b0;
      end else begin
        snap_ready = 1'b1; cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout left %0d want 0", exp_q.size()); end
    checks++; if (held != 10) begin errors++; $display("FAIL bp_held got %0d want 10", held); end
    step();
    step();
    checks++; if (debug_banksel !== 2'd0) begin errors++; $display("FAIL bp_end_sel got %0d want 0", debug_banksel); end
    checks++; if (debug_wait !== 1'b1) begin errors++; $display("FAIL bp_end_wait got %b want 1", debug_wait); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_end_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_reset_mid();
    logic [49:0] e;
    logic aborted;
    int late;
    aborted = 1'b0; late = 0; snap_ready = 1'b1;
    push_all();
    cmd_valid = 1'b1; cmd_op = OP_SNAP;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 60 && !aborted; k++) begin
      step();
      if (snap_valid && snap_bank == 2'd2) begin
        checks++; if (exp_q.size() != 2) begin errors++; $display("FAIL rm_pending got %0d want 2", exp_q.size()); end
        exp_q.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        aborted = 1'b1;
        checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b want 0", snap_valid); end
        checks++; if (debug_banksel !== 2'd0) begin errors++; $display("FAIL rm_sel got %0d want 0", debug_banksel); end
        checks++; if (debug_wait !== 1'b1) begin errors++; $display("FAIL rm_wait got %b want 1", debug_wait); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", cmd_ready); end
      end else if (snap_valid) begin
        e = exp_q.pop_front();
        checks++; if (snap_data !== e[47:0]) begin errors++; $display("FAIL rm_data got %h want %h", snap_data, e[47:0]); end
      end
    end
    checks++; if (!aborted) begin errors++; $display("FAIL rm_timeout got no bank2 record want one"); end
    for (int k = 0; k < 20; k++) begin
      step();
      if (snap_valid || debug_banksel != 2'd0) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL rm_no_more got %0d active cycles want 0", late); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; brk_ena = 1'b0; brk_addr = 16'h0000;
    snap_ready = 1'b1; snap_mode = 1'b0; addr_drv = 16'h0000; m1_drv = 1'b0;
    test_reset();
    test_breakpoint();
    test_step();
    test_snapshot();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
